// File: rtl/instr_mem_pkg.sv
// rtl/instr_mem_pkg.sv - shared types, constants and address decode for the instruction-memory responder
package instr_mem_pkg;

    localparam int XLEN        = 32;
    localparam int MAX_LATENCY = 4;

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] data;
    } resp_t;

    // Returns the word index of addr relative to base. ok is low for a misaligned
    // address or one outside [base, base+span); addresses below base wrap high.
    function automatic logic [XLEN-1:0] addr_to_idx(
        input  logic [XLEN-1:0] addr,
        input  logic [XLEN-1:0] base,
        input  logic [XLEN-1:0] span,
        output logic            ok
    );
        logic [XLEN-1:0] off;
        off = addr - base;
        ok  = (addr[1:0] == 2'b00) && (off < span);
        return off >> 2;
    endfunction

endpackage

// File: rtl/instr_mem_responder_delay.sv
// rtl/instr_mem_responder_delay.sv - fixed-latency response shift register (resp_delay_line)
module resp_delay_line
    import instr_mem_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic  clk,
    input  logic  rstn,
    input  resp_t in_resp,
    output resp_t out_resp
);

    resp_t tail_in;
    resp_t tail_q;

    generate
        if (LATENCY == 1) begin : g_direct
            assign tail_in = in_resp;
        end else begin : g_pipe
            logic [LATENCY-2:0] valid_q;
            logic [LATENCY-2:0] err_q;
            logic [XLEN-1:0]    data_q [LATENCY-1];

            // Only the valid bits are cleared so a reset drops every in-flight response.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= in_resp.valid;
                    for (int i = 1; i < LATENCY - 1; i++) begin
                        valid_q[i] <= valid_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                err_q[0]  <= in_resp.err;
                data_q[0] <= in_resp.data;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    err_q[i]  <= err_q[i-1];
                    data_q[i] <= data_q[i-1];
                end
            end

            assign tail_in = '{valid: valid_q[LATENCY-2],
                               err:   err_q[LATENCY-2],
                               data:  data_q[LATENCY-2]};
        end
    endgenerate

    // The tail feeds the port directly, so it is fully reset to give clean outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tail_q <= '0;
        end else begin
            tail_q <= tail_in;
        end
    end

    assign out_resp = tail_q;

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - req/gnt/rvalid instruction memory with program-load write port
module instr_mem_responder
    import instr_mem_pkg::*;
#(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic [31:0] instr_rdata_o,
    output logic        instr_err_o,
    input  logic        prog_we_i,
    input  logic [31:0] prog_addr_i,
    input  logic [31:0] prog_wdata_i,
    input  logic        gnt_stall_i
);

    localparam int              IDX_W    = $clog2(MEM_WORDS);
    localparam logic [XLEN-1:0] MEM_SPAN = XLEN'(MEM_WORDS * 4);
    localparam logic [2:0]      MAX_OUT  = 3'(MAX_OUTSTANDING);

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("LATENCY out of range");
        end
        if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > 7) begin : g_bad_outstanding
            $error("MAX_OUTSTANDING out of range");
        end
        if ((MEM_WORDS & (MEM_WORDS - 1)) != 0) begin : g_bad_depth
            $error("MEM_WORDS must be a power of two");
        end
    endgenerate

    logic [XLEN-1:0]  mem [MEM_WORDS];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    logic             rd_ok;
    logic             wr_ok;
    logic             gnt;
    logic [2:0]       outstanding;
    resp_t            push_resp;
    resp_t            tail_resp;

    always_comb begin
        rd_ok  = 1'b0;
        wr_ok  = 1'b0;
        rd_idx = IDX_W'(addr_to_idx(instr_addr_i, BASE_ADDR, MEM_SPAN, rd_ok));
        wr_idx = IDX_W'(addr_to_idx(prog_addr_i, BASE_ADDR, MEM_SPAN, wr_ok));
    end

    // A response in its rvalid cycle is still counted, so a full counter blocks
    // the grant until the cycle after it retires.
    assign gnt = instr_req_i & ~gnt_stall_i & ~prog_we_i & (outstanding < MAX_OUT) & rstn;

    always_comb begin
        push_resp       = '0;
        push_resp.valid = gnt;
        push_resp.err   = ~rd_ok;
        push_resp.data  = rd_ok ? mem[rd_idx] : '0;
    end

    // Contents are deliberately not reset so a loaded image survives rstn.
    always_ff @(posedge clk) begin
        if (prog_we_i && wr_ok) begin
            mem[wr_idx] <= prog_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= '0;
        end else begin
            case ({gnt, tail_resp.valid})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    resp_delay_line #(
        .LATENCY (LATENCY)
    ) u_delay (
        .clk      (clk),
        .rstn     (rstn),
        .in_resp  (push_resp),
        .out_resp (tail_resp)
    );

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = tail_resp.valid;
    assign instr_rdata_o  = tail_resp.data;
    assign instr_err_o    = tail_resp.err;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
        tail_resp.valid |-> (outstanding != 3'd0));

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - randomized self-checking bench with a queue-based response model
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        req = 1'b0;
    logic        gnt_stall = 1'b0;
    logic        prog_we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] prog_addr = '0;
    logic [31:0] prog_wdata = '0;
    int          sel = 0;

    logic        gnt_v    [3];
    logic        rvalid_v [3];
    logic        err_v    [3];
    logic [31:0] rdata_v  [3];

    int          cfg_lat  [3] = '{1, 3, 2};
    int          cfg_max  [3] = '{2, 2, 2};
    logic [31:0] cfg_base [3] = '{32'h0, 32'h0, 32'h2000};

    always #5 clk = ~clk;

    instr_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(1), .MAX_OUTSTANDING(2)) u_l1 (
        .clk(clk), .rstn(rstn), .instr_req_i(req && sel == 0), .instr_addr_i(addr),
        .instr_gnt_o(gnt_v[0]), .instr_rvalid_o(rvalid_v[0]), .instr_rdata_o(rdata_v[0]),
        .instr_err_o(err_v[0]), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
        .prog_wdata_i(prog_wdata), .gnt_stall_i(gnt_stall));

    instr_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h0), .LATENCY(3), .MAX_OUTSTANDING(2)) u_l3 (
        .clk(clk), .rstn(rstn), .instr_req_i(req && sel == 1), .instr_addr_i(addr),
        .instr_gnt_o(gnt_v[1]), .instr_rvalid_o(rvalid_v[1]), .instr_rdata_o(rdata_v[1]),
        .instr_err_o(err_v[1]), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
        .prog_wdata_i(prog_wdata), .gnt_stall_i(gnt_stall));

    instr_mem_responder #(.MEM_WORDS(1024), .BASE_ADDR(32'h2000), .LATENCY(2), .MAX_OUTSTANDING(2)) u_l2 (
        .clk(clk), .rstn(rstn), .instr_req_i(req && sel == 2), .instr_addr_i(addr),
        .instr_gnt_o(gnt_v[2]), .instr_rvalid_o(rvalid_v[2]), .instr_rdata_o(rdata_v[2]),
        .instr_err_o(err_v[2]), .prog_we_i(prog_we), .prog_addr_i(prog_addr),
        .prog_wdata_i(prog_wdata), .gnt_stall_i(gnt_stall));

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic [31:0] mm [3][1024];
    exp_t        q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic        eg, ev, ee, og, ov, oe;
    logic [31:0] ed, od;

    // Advances one clock: samples the selected DUT at the falling edge, derives the
    // expected outputs from the request queue, then updates the model state.
    task automatic tick();
        exp_t        e;
        logic [31:0] off;
        @(negedge clk);
        og = gnt_v[sel];
        ov = rvalid_v[sel];
        od = rdata_v[sel];
        oe = err_v[sel];
        if (!rstn) begin
            q.delete();
            eg = 1'b0; ev = 1'b0; ed = '0; ee = 1'b0;
        end else begin
            eg = req && !gnt_stall && !prog_we && (q.size() < cfg_max[sel]);
            ev = (q.size() > 0) && (q[0].due == cyc);
            ed = ev ? q[0].data : '0;
            ee = ev ? q[0].err : 1'b0;
            if (ev) void'(q.pop_front());
            if (eg) begin
                off    = addr - cfg_base[sel];
                e.err  = (addr % 4 != 0) || (off >= 32'd4096);
                e.data = e.err ? 32'h0 : mm[sel][off[11:2]];
                e.due  = cyc + cfg_lat[sel];
                q.push_back(e);
            end
        end
        if (prog_we) begin
            for (int d = 0; d < 3; d++) begin
                off = prog_addr - cfg_base[d];
                if (prog_addr % 4 == 0 && off < 32'd4096) mm[d][off[11:2]] = prog_wdata;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rstn = 1'b0; req = 1'b0; gnt_stall = 1'b0; prog_we = 1'b0;
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        prog_we = 1'b1; prog_addr = a; prog_wdata = d;
        tick();
        prog_we = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = 1'b1; addr = '0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            tick();
            n_checks++; if (og !== 1'b0) begin n_fail++; $display("FAIL reset_gnt dut=%0d got=%b exp=0", s, og); end
            n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid dut=%0d got=%b exp=0", s, ov); end
            n_checks++; if (od !== 32'h0 || oe !== 1'b0) begin
                n_fail++; $display("FAIL reset_rdata dut=%0d got=%h/%b exp=0/0", s, od, oe);
            end
        end
        req = 1'b0;
        rstn = 1'b1;
        tick();
    endtask

    task automatic preload();
        for (int i = 0; i < 64; i++) prog_write(32'(i * 4), $urandom);
        for (int i = 0; i < 64; i++) prog_write(32'h2000 + 32'(i * 4), $urandom);
        prog_write(32'h0, 32'h11);
        prog_write(32'h4, 32'h22);
        prog_write(32'h8, 32'h33);
        prog_write(32'hC, 32'h44);
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
        int k = 0;
        sel = 0;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req = (k < 4);
            if (k < 4) addr = seq[k];
            tick();
            n_checks++; if (og !== eg) begin n_fail++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); end
            n_checks++; if (ov !== ev) begin n_fail++; $display("FAIL b2b_rvalid cyc=%0d got=%b exp=%b", cyc, ov, ev); end
            if (ev) begin n_checks++; if (od !== ed || oe !== ee) begin
                n_fail++; $display("FAIL b2b_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, od, oe, ed, ee); end end
            if (og && k < 4) k++;
        end
        n_checks++; if (k != 4) begin n_fail++; $display("FAIL b2b_grants got=%0d exp=4", k); end
    endtask

    task automatic test_latency3();
        int k = 0;
        sel = 1;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            req = (k < 6);
            addr = 32'h20 + 32'(k * 4);
            tick();
            n_checks++; if (og !== eg) begin n_fail++; $display("FAIL lat3_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); end
            n_checks++; if (ov !== ev) begin n_fail++; $display("FAIL lat3_rvalid cyc=%0d got=%b exp=%b", cyc, ov, ev); end
            if (ev) begin n_checks++; if (od !== ed || oe !== ee) begin
                n_fail++; $display("FAIL lat3_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, od, oe, ed, ee); end end
            if (og && k < 6) k++;
        end
        n_checks++; if (k != 6 || q.size() != 0) begin
            n_fail++; $display("FAIL lat3_done grants=%0d pending=%0d exp=6/0", k, q.size());
        end
    endtask

    task automatic test_error();
        logic [31:0] bad [2][4] = '{'{32'h2, 32'h1000, 32'h40, 32'h3},
                                    '{32'h1FFC, 32'h2002, 32'h3000, 32'h2010}};
        int k;
        for (int s = 0; s < 3; s += 2) begin
            sel = s;
            do_reset();
            k = 0;
            for (int c = 0; c < 14; c++) begin
                req = (k < 4) || (c == 13);
                addr = (k < 4) ? bad[s/2][k] : cfg_base[s];
                tick();
                n_checks++; if (og !== eg) begin n_fail++; $display("FAIL err_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); end
                n_checks++; if (ov !== ev) begin n_fail++; $display("FAIL err_rvalid cyc=%0d got=%b exp=%b", cyc, ov, ev); end
                if (ev) begin n_checks++; if (od !== ed || oe !== ee) begin
                    n_fail++; $display("FAIL err_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, od, oe, ed, ee); end end
                if (c == 13) begin n_checks++; if (og !== 1'b1) begin
                    n_fail++; $display("FAIL err_regrant dut=%0d got=%b exp=1", s, og); end end
                if (og && k < 4) k++;
            end
            req = 1'b0;
            for (int c = 0; c < 4; c++) tick();
        end
    endtask

    task automatic test_read_then_write();
        logic [31:0] old_val;
        logic [31:0] last = '0;
        logic        done = 1'b0;
        sel = 0;
        do_reset();
        old_val = mm[0][4];
        req = 1'b1; addr = 32'h10;
        tick();
        n_checks++; if (og !== 1'b1) begin n_fail++; $display("FAIL rtw_grant got=%b exp=1", og); end
        prog_we = 1'b1; prog_addr = 32'h10; prog_wdata = 32'hDEAD; addr = 32'h14;
        tick();
        prog_we = 1'b0;
        n_checks++; if (og !== 1'b0) begin n_fail++; $display("FAIL rtw_we_blocks_gnt got=%b exp=0", og); end
        n_checks++; if (ov !== 1'b1 || od !== old_val) begin
            n_fail++; $display("FAIL rtw_old_value got=%b/%h exp=1/%h", ov, od, old_val);
        end
        addr = 32'h10;
        for (int c = 0; c < 6; c++) begin
            req = !done;
            tick();
            n_checks++; if (og !== eg) begin n_fail++; $display("FAIL rtw_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); end
            n_checks++; if (ov !== ev) begin n_fail++; $display("FAIL rtw_rvalid cyc=%0d got=%b exp=%b", cyc, ov, ev); end
            if (ev) begin n_checks++; if (od !== ed || oe !== ee) begin
                n_fail++; $display("FAIL rtw_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, od, oe, ed, ee); end end
            if (ov) last = od;
            if (og) done = 1'b1;
        end
        n_checks++; if (last !== 32'hDEAD) begin n_fail++; $display("FAIL rtw_new_value got=%h exp=0000dead", last); end
    endtask

    task automatic test_mid_reset();
        sel = 2;
        do_reset();
        req = 1'b1; addr = 32'h2000;
        tick();
        addr = 32'h2004;
        tick();
        n_checks++; if (q.size() != 2 || !og) begin
            n_fail++; $display("FAIL mrst_two_grants pending=%0d gnt=%b exp=2/1", q.size(), og);
        end
        rstn = 1'b0; req = 1'b0;
        tick();
        n_checks++; if (ov !== 1'b0 || og !== 1'b0) begin
            n_fail++; $display("FAIL mrst_in_reset rvalid=%b gnt=%b exp=0/0", ov, og);
        end
        rstn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++; if (ov !== 1'b0) begin n_fail++; $display("FAIL mrst_stale_rvalid cyc=%0d got=%b exp=0", cyc, ov); end
        end
        req = 1'b1; addr = 32'h2008;
        tick();
        n_checks++; if (og !== 1'b1) begin n_fail++; $display("FAIL mrst_first_grant got=%b exp=1", og); end
        req = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (ov !== ev) begin n_fail++; $display("FAIL mrst_rvalid cyc=%0d got=%b exp=%b", cyc, ov, ev); end
            if (ev) begin n_checks++; if (od !== ed || oe !== ee) begin
                n_fail++; $display("FAIL mrst_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, od, oe, ed, ee); end end
        end
    endtask

    task automatic test_stall_random();
        int n_gnt = 0;
        int n_rsp = 0;
        int r;
        for (int s = 1; s < 3; s++) begin
            sel = s;
            do_reset();
            addr = cfg_base[s];
            for (int c = 0; c < 310; c++) begin
                req = (c < 300);
                gnt_stall = $urandom_range(0, 1);
                tick();
                n_checks++; if (og !== eg) begin n_fail++; $display("FAIL stall_gnt cyc=%0d got=%b exp=%b", cyc, og, eg); end
                n_checks++; if (ov !== ev) begin n_fail++; $display("FAIL stall_rvalid cyc=%0d got=%b exp=%b", cyc, ov, ev); end
                if (ev) begin n_checks++; if (od !== ed || oe !== ee) begin
                    n_fail++; $display("FAIL stall_resp cyc=%0d got=%h/%b exp=%h/%b", cyc, od, oe, ed, ee); end end
                if (og) begin
                    n_gnt++;
                    r = $urandom_range(0, 15);
                    if (r == 0)      addr = cfg_base[s] + 32'h1000;
                    else if (r == 1) addr = cfg_base[s] + 32'($urandom_range(0, 63) * 4 + 1);
                    else             addr = cfg_base[s] + 32'($urandom_range(0, 63) * 4);
                end
                if (ov) n_rsp++;
            end
            gnt_stall = 1'b0;
        end
        n_checks++; if (n_gnt != n_rsp || q.size() != 0) begin
            n_fail++; $display("FAIL stall_balance grants=%0d responses=%0d pending=%0d", n_gnt, n_rsp, q.size());
        end
    endtask

    initial begin
        test_reset();
        preload();
        test_back_to_back();
        test_latency3();
        test_error();
        test_read_then_write();
        test_mid_reset();
        test_stall_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
